ztest_channel_scheduler: RTL and testbench
==========================================

// Module: ztest_channel_scheduler
// PURPOSE
//  Time-multiplexes one z-test spike-detection datapath across NUM_CH electrode channels.
//  Arbitrates per-channel sample requests round-robin and forwards one sample per accepted
//  transfer, tagged with its channel id. Sequences each channel's training phase
//  (TRAIN_SAMPLES samples) and its switch to operation. Supports per-channel retrain commands.
//  Sits between the channel front-ends (ADC/decimators) and the shared detector core.
// PARAMETERS
//  NUM_CH         4    number of channels sharing the core (>=2)
//  CH_W           2    channel-id width, = clog2(NUM_CH)
//  TRAIN_SAMPLES  128  training samples per channel before operation
//  CNT_W          8    training-counter width, >= clog2(TRAIN_SAMPLES+1)
// PORTS
//  clk              in   1         clock
//  rst              in   1         reset
//  req_valid        in   NUM_CH    per-channel sample valid
//  req_data         in   16*NUM_CH signed samples; channel i occupies [16*i+15:16*i]
//  req_ready        out  NUM_CH    per-channel accept (combinational, one-hot or zero)
//  retrain          in   NUM_CH    per-channel 1-cycle retrain pulse
//  core_valid       out  1         registered sample valid to detector core
//  core_ready       in   1         core accepts the sample
//  core_ch          out  CH_W      channel id of core_data
//  core_data        out  16        signed sample
//  core_train       out  1         sample belongs to the training phase
//  core_train_last  out  1         last training sample; core computes the channel mean
//  ch_trained       out  NUM_CH    channel i is in operation
// BEHAVIOUR
//  Reset: rst is asynchronous, active-high; clock is clk. Outputs return to 0 immediately.
//   Applies to core_valid, core_ch, core_data, core_train, core_train_last and ch_trained.
//   Training counters clear to 0. RR pointer is set to NUM_CH-1, so ch0 has first priority.
//   Reset mid-transfer discards the held sample, with no partial state kept.
//  Output slot: a single register. load_en = !core_valid || core_ready.
//   While core_valid=1 and core_ready=0, all core_* outputs hold stable and req_ready=0.
//  Arbitration (combinational, per cycle): eligible[i] = req_valid[i] && !retrain[i].
//   When load_en=1, grant the first eligible channel searching from ptr+1 upward, mod NUM_CH.
//   req_ready[grant]=1. A transfer occurs when req_valid && req_ready.
//   ptr takes the granted index. Latency: accepted sample appears on core_* the next cycle.
//   No grant while load_en=1 -> core_valid falls to 0 on the next edge.
//   Fairness: a continuously-valid channel is granted within NUM_CH transfers.
//  Per-channel FSM: TRAIN -> RUN.
//   TRAIN: each accepted sample sets core_train=1 and increments cnt[i].
//    When cnt[i]==TRAIN_SAMPLES-1, that sample also carries core_train_last=1.
//    In the same cycle cnt[i] saturates at TRAIN_SAMPLES, the state goes to RUN and ch_trained[i] is set.
//   RUN: samples are forwarded with core_train=0 and core_train_last=0. cnt[i] holds.
//   retrain[i] (any state): next cycle cnt[i]=0, state=TRAIN, ch_trained[i]=0.
//    Channel i is not granted in the retrain cycle, so retrain always takes precedence.
//    A sample of channel i already in the output register is unaffected.
//   Retrain of one channel never disturbs the state or the RR pointer of other channels.
//  Arithmetic: no data math; req_data passes bit-exact. Counters never wrap (saturate).
// TESTING
//  T1: only ch0 valid, core_ready=1.
//   -> 128 samples with core_train=1; the 128th has core_train_last=1.
//   -> ch_trained=4'b0001 the cycle after. Sample 129 has core_train=0.
//  T2: all 4 channels valid continuously, core_ready=1.
//   -> core_ch sequence 0,1,2,3,0,1... and req_ready one-hot every cycle.
//  T3: core_ready=0 for 5 cycles with core_valid=1, core_data=16'sh7FFF, core_ch=2.
//   -> outputs stable and req_ready=0 throughout; stream resumes with ch3 after core_ready=1.
//  T4: ch2 in RUN; retrain[2] pulsed while req_valid[2]=1.
//   -> no ch2 grant that cycle; ch_trained[2]=0 next cycle; next ch2 sample has core_train=1.
//   -> ch2 needs 128 new samples; ch0, ch1 and ch3 are unaffected.
//  T5: only ch1 and ch3 valid -> grants alternate 1,3,1,3.
//   -> -32768 and 32767 sample values pass unchanged.
//  T6: assert rst mid-stream with core_valid=1.
//   -> all outputs 0 without a clock edge; after release the first grant is ch0 if it is valid.

Source files
------------

// File: rtl/ztest_channel_scheduler.sv
// ztest_channel_scheduler: round-robin sharing of one z-test detector core across channels, with per-channel train/run sequencing
module ztest_channel_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int TRAIN_SAMPLES = 128,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req_valid,
  input  logic [16*NUM_CH-1:0]   req_data,
  output logic [NUM_CH-1:0]      req_ready,
  input  logic [NUM_CH-1:0]      retrain,
  output logic                   core_valid,
  input  logic                   core_ready,
  output logic [CH_W-1:0]        core_ch,
  output logic signed [15:0]     core_data,
  output logic                   core_train,
  output logic                   core_train_last,
  output logic [NUM_CH-1:0]      ch_trained
);
  typedef enum logic {TRAIN, RUN} state_t;
  state_t           state    [NUM_CH];
  state_t           state_nx [NUM_CH];
  logic [CNT_W-1:0] cnt      [NUM_CH];
  logic [CNT_W-1:0] cnt_nx   [NUM_CH];
  logic [CH_W-1:0]  ptr, gnt;
  logic [NUM_CH-1:0] eligible;
  logic [15:0]      gnt_data;
  logic             found, load_en;
  int               j;
  always_comb begin
    load_en  = !core_valid || core_ready;
    eligible = req_valid & ~retrain;
    found    = 1'b0;
    gnt      = ptr;
    gnt_data = '0;
    j        = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = (int'(ptr) + k) % NUM_CH;
      if (!found && eligible[j]) begin
        found    = 1'b1;
        gnt      = CH_W'(j);
        gnt_data = req_data[16*j +: 16];
      end
    end
    req_ready = (load_en && found) ? {{(NUM_CH-1){1'b0}}, 1'b1} << gnt : '0;
  end
  // retrain wins outright: a retraining channel is never eligible, so it cannot also transfer
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nx[i]   = state[i];
      cnt_nx[i]     = cnt[i];
      ch_trained[i] = state[i] == RUN;
      if (retrain[i]) begin
        state_nx[i] = TRAIN;
        cnt_nx[i]   = '0;
      end else if (req_ready[i] && req_valid[i] && state[i] == TRAIN) begin
        cnt_nx[i]   = cnt[i] + 1'b1;
        state_nx[i] = (cnt[i] == CNT_W'(TRAIN_SAMPLES-1)) ? RUN : TRAIN;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= TRAIN;
        cnt[i]   <= '0;
      end
      ptr             <= CH_W'(NUM_CH-1);
      core_valid      <= 1'b0;
      core_ch         <= '0;
      core_data       <= '0;
      core_train      <= 1'b0;
      core_train_last <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      if (load_en) begin
        core_valid <= found;
        if (found) begin
          ptr             <= gnt;
          core_ch         <= gnt;
          core_data       <= gnt_data;
          core_train      <= state[gnt] == TRAIN;
          core_train_last <= state[gnt] == TRAIN && cnt[gnt] == CNT_W'(TRAIN_SAMPLES-1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ztest_channel_scheduler.sv
// tb_ztest_channel_scheduler: directed vectors with hand-computed expectations for the channel scheduler
module tb_ztest_channel_scheduler;
  logic        clk = 0, rst = 1;
  logic [3:0]  req_valid = '0, req_ready, retrain = '0, ch_trained;
  logic [63:0] req_data = '0;
  logic        core_valid, core_ready = 0, core_train, core_train_last;
  logic [1:0]  core_ch;
  logic [15:0] core_data;
  int total = 0, bad = 0;
  int exp_ch;

  ztest_channel_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .retrain(retrain), .core_valid(core_valid), .core_ready(core_ready), .core_ch(core_ch),
    .core_data(core_data), .core_train(core_train), .core_train_last(core_train_last),
    .ch_trained(ch_trained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all();
    for (int c = 0; c < 4; c++) req_data[16*c +: 16] = 16'h0A00 + 16'(c);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(core_valid), 0);
    chk("rst_data", 32'(core_data), 0);
    chk("rst_trained", 32'(ch_trained), 0);
    tick();
    tick();
    rst = 0;
    // T1: ch0 alone through its whole training phase
    req_valid  = 4'b0001;
    core_ready = 1;
    for (int n = 1; n <= 129; n++) begin
      req_data[15:0] = 16'(n);
      #1;
      chk("t1_ready", 32'(req_ready), 4'b0001);
      tick();
      chk("t1_valid", 32'(core_valid), 1);
      chk("t1_data", 32'(core_data), 32'(n));
      chk("t1_train", 32'(core_train), 32'(n <= 128));
      chk("t1_last", 32'(core_train_last), 32'(n == 128));
      chk("t1_trained", 32'(ch_trained), (n >= 128) ? 4'b0001 : 4'b0000);
    end
    // T2: all channels valid, rotation resumes after ch0
    req_valid = 4'b1111;
    set_all();
    exp_ch = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_ready", 32'(req_ready), 32'(4'b0001 << exp_ch));
      tick();
      chk("t2_ch", 32'(core_ch), 32'(exp_ch));
      chk("t2_data", 32'(core_data), 32'h0A00 + 32'(exp_ch));
      chk("t2_train", 32'(core_train), 32'(exp_ch != 0));
      exp_ch = (exp_ch + 1) % 4;
    end
    // T3: backpressure holds ch2's sample
    req_valid = 4'b0100;
    req_data[47:32] = 16'h7FFF;
    tick();
    chk("t3_ch", 32'(core_ch), 2);
    core_ready = 0;
    req_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_ready", 32'(req_ready), 0);
      chk("t3_valid", 32'(core_valid), 1);
      chk("t3_hold_ch", 32'(core_ch), 2);
      chk("t3_hold_data", 32'(core_data), 32'h7FFF);
      tick();
    end
    core_ready = 1;
    #1;
    chk("t3_resume_ready", 32'(req_ready), 4'b1000);
    tick();
    chk("t3_resume_ch", 32'(core_ch), 3);
    // fresh training of ch2 from zero
    retrain   = 4'b0100;
    req_valid = 4'b0000;
    tick();
    retrain = 0;
    chk("idle_valid", 32'(core_valid), 0);
    chk("rt_trained", 32'(ch_trained), 4'b0001);
    req_valid = 4'b0100;
    for (int n = 1; n <= 128; n++) begin
      req_data[47:32] = 16'(n);
      tick();
      chk("tr2_data", 32'(core_data), 32'(n));
      chk("tr2_last", 32'(core_train_last), 32'(n == 128));
    end
    chk("tr2_trained", 32'(ch_trained), 4'b0101);
    // T4: retrain ch2 while it requests
    req_valid = 4'b1111;
    retrain   = 4'b0100;
    set_all();
    #1;
    chk("t4_ready", 32'(req_ready), 4'b1000);
    tick();
    retrain = 0;
    chk("t4_trained", 32'(ch_trained), 4'b0001);
    chk("t4_ch", 32'(core_ch), 3);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_seq_ch", 32'(core_ch), 32'(c));
      chk("t4_seq_train", 32'(core_train), 32'(c != 0));
    end
    chk("t4_data", 32'(core_data), 32'h0A02);
    chk("t4_trained2", 32'(ch_trained), 4'b0001);
    // T5: ch1/ch3 alternate, extreme values pass unchanged
    req_valid = 4'b1010;
    req_data[31:16] = 16'h8000;
    req_data[63:48] = 16'h7FFF;
    exp_ch = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_ch", 32'(core_ch), 32'(exp_ch));
      chk("t5_data", 32'(core_data), (exp_ch == 1) ? 32'h8000 : 32'h7FFF);
      exp_ch = (exp_ch == 3) ? 1 : 3;
    end
    // T6: asynchronous reset mid-stream
    rst = 1;
    #1;
    chk("t6_valid", 32'(core_valid), 0);
    chk("t6_ch", 32'(core_ch), 0);
    chk("t6_data", 32'(core_data), 0);
    chk("t6_train", 32'(core_train), 0);
    chk("t6_last", 32'(core_train_last), 0);
    chk("t6_trained", 32'(ch_trained), 0);
    tick();
    req_valid = 4'b1111;
    rst = 0;
    #1;
    chk("t6_ready", 32'(req_ready), 4'b0001);
    tick();
    chk("t6_first_ch", 32'(core_ch), 0);
    chk("t6_first_train", 32'(core_train), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
